// File: rtl/comparator_array.sv
// Purpose: per-lane threshold compare (f<w, f<=w, f>w, f==w) with OR/AND/popcount reduction and a response counter.
// Latency: 2 cycles, accept in cycle N and respond in cycle N+2; one request per cycle sustained while io_resp_ready is high.
// Backpressure: io_req_ready = !a_valid || !b_valid || io_resp_ready; with both stages full and io_resp_ready low it drops to 0.
// Ports: clk/reset_n (async active-low); io_req_* request (feature/weights packed lane0 in LSBs, op, tag);
//        io_resp_* response (decision, any, all, count, tag); io_stat_clear/io_stat_count handshake counter.
module comparator_array #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         io_req_valid,
  output logic                         io_req_ready,
  input  logic [LANES*WIDTH-1:0]       io_req_bits_feature,
  input  logic [LANES*WIDTH-1:0]       io_req_bits_weights,
  input  logic [1:0]                   io_req_bits_op,
  input  logic [TAG_W-1:0]             io_req_bits_tag,
  output logic                         io_resp_valid,
  input  logic                         io_resp_ready,
  output logic [LANES-1:0]             io_resp_bits_decision,
  output logic                         io_resp_bits_any,
  output logic                         io_resp_bits_all,
  output logic [$clog2(LANES+1)-1:0]   io_resp_bits_count,
  output logic [TAG_W-1:0]             io_resp_bits_tag,
  input  logic                         io_stat_clear,
  output logic [15:0]                  io_stat_count
);

  localparam int CW = $clog2(LANES+1);

  // Flipping the MSB maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  // Stage A: captured request
  logic                   a_valid;
  logic [LANES*WIDTH-1:0] a_feature;
  logic [LANES*WIDTH-1:0] a_weights;
  logic [1:0]             a_op;
  logic [TAG_W-1:0]       a_tag;

  // Stage B: registered response
  logic                   b_valid;
  logic [LANES-1:0]       b_decision;
  logic                   b_any;
  logic                   b_all;
  logic [CW-1:0]          b_count;
  logic [TAG_W-1:0]       b_tag;

  logic                   req_hs;
  logic                   resp_hs;
  logic                   a_to_b;

  logic [LANES-1:0]       decision;
  logic [CW-1:0]          count;
  logic [WIDTH-1:0]       lane_f;
  logic [WIDTH-1:0]       lane_w;

  logic [15:0]            stat_count;

  assign io_req_ready = !a_valid || !b_valid || io_resp_ready;
  assign req_hs       = io_req_valid && io_req_ready;
  assign resp_hs      = b_valid && io_resp_ready;
  assign a_to_b       = a_valid && (!b_valid || io_resp_ready);

  always_comb begin
    decision = '0;
    lane_f   = '0;
    lane_w   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_f = a_feature[i*WIDTH +: WIDTH] ^ SIGN_MASK;
      lane_w = a_weights[i*WIDTH +: WIDTH] ^ SIGN_MASK;
      unique case (a_op)
        2'b00:   decision[i] = lane_f <  lane_w;
        2'b01:   decision[i] = lane_f <= lane_w;
        2'b10:   decision[i] = lane_f >  lane_w;
        default: decision[i] = lane_f == lane_w;
      endcase
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      count = count + CW'(decision[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid   <= 1'b0;
      a_feature <= '0;
      a_weights <= '0;
      a_op      <= '0;
      a_tag     <= '0;
    end else begin
      if (req_hs) begin
        a_valid   <= 1'b1;
        a_feature <= io_req_bits_feature;
        a_weights <= io_req_bits_weights;
        a_op      <= io_req_bits_op;
        a_tag     <= io_req_bits_tag;
      end else if (a_to_b) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Data registers reset as well so the response bits read 0 during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_valid    <= 1'b0;
      b_decision <= '0;
      b_any      <= 1'b0;
      b_all      <= 1'b0;
      b_count    <= '0;
      b_tag      <= '0;
    end else begin
      if (a_to_b) begin
        b_valid    <= 1'b1;
        b_decision <= decision;
        b_any      <= |decision;
        b_all      <= &decision;
        b_count    <= count;
        b_tag      <= a_tag;
      end else if (resp_hs) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_count <= '0;
    end else if (io_stat_clear) begin
      stat_count <= '0;
    end else if (resp_hs && (stat_count != 16'hFFFF)) begin
      stat_count <= stat_count + 16'd1;
    end
  end

  assign io_resp_valid         = b_valid;
  assign io_resp_bits_decision = b_decision;
  assign io_resp_bits_any      = b_any;
  assign io_resp_bits_all      = b_all;
  assign io_resp_bits_count    = b_count;
  assign io_resp_bits_tag      = b_tag;
  assign io_stat_count         = stat_count;

endmodule

// File: tb/tb_comparator_array.sv
// Purpose: exercises an unsigned and a signed comparator_array side by side with shared stimulus.
// Latency: expected responses are queued at acceptance and popped on each response handshake.
// Backpressure: io_resp_ready is driven directed and randomly; held outputs are checked while stalled.
module tb_comparator_array;

  typedef struct packed {
    logic [3:0] dec_u;
    logic [3:0] dec_s;
    logic [3:0] tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         req_valid = 1'b0;
  logic [127:0] req_feature = '0;
  logic [127:0] req_weights = '0;
  logic [1:0]   req_op = '0;
  logic [3:0]   req_tag = '0;
  logic         resp_ready = 1'b0;
  logic         stat_clear = 1'b0;

  logic         u_req_ready, s_req_ready;
  logic         u_resp_valid, s_resp_valid;
  logic [3:0]   u_dec, s_dec;
  logic         u_any, s_any, u_all, s_all;
  logic [2:0]   u_cnt, s_cnt;
  logic [3:0]   u_tag, s_tag;
  logic [15:0]  u_stat, s_stat;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   resp_seen = 0;

  always #5 clk = ~clk;

  comparator_array #(.WIDTH(32), .LANES(4), .SIGNED(0), .TAG_W(4)) dut_u (
    .clk(clk), .reset_n(reset_n),
    .io_req_valid(req_valid), .io_req_ready(u_req_ready),
    .io_req_bits_feature(req_feature), .io_req_bits_weights(req_weights),
    .io_req_bits_op(req_op), .io_req_bits_tag(req_tag),
    .io_resp_valid(u_resp_valid), .io_resp_ready(resp_ready),
    .io_resp_bits_decision(u_dec), .io_resp_bits_any(u_any), .io_resp_bits_all(u_all),
    .io_resp_bits_count(u_cnt), .io_resp_bits_tag(u_tag),
    .io_stat_clear(stat_clear), .io_stat_count(u_stat)
  );

  comparator_array #(.WIDTH(32), .LANES(4), .SIGNED(1), .TAG_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .io_req_valid(req_valid), .io_req_ready(s_req_ready),
    .io_req_bits_feature(req_feature), .io_req_bits_weights(req_weights),
    .io_req_bits_op(req_op), .io_req_bits_tag(req_tag),
    .io_resp_valid(s_resp_valid), .io_resp_ready(resp_ready),
    .io_resp_bits_decision(s_dec), .io_resp_bits_any(s_any), .io_resp_bits_all(s_all),
    .io_resp_bits_count(s_cnt), .io_resp_bits_tag(s_tag),
    .io_stat_clear(stat_clear), .io_stat_count(s_stat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each lane compared as a mathematical integer.
  function automatic logic [3:0] model(input logic [127:0] f, input logic [127:0] w,
                                       input logic [1:0] op, input bit sgn);
    logic [3:0] d;
    longint     a;
    longint     b;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sgn) begin
        a = longint'($signed(f[i*32 +: 32]));
        b = longint'($signed(w[i*32 +: 32]));
      end else begin
        a = longint'(f[i*32 +: 32]);
        b = longint'(w[i*32 +: 32]);
      end
      case (op)
        2'd0:    d[i] = (a <  b);
        2'd1:    d[i] = (a <= b);
        2'd2:    d[i] = (a >  b);
        default: d[i] = (a == b);
      endcase
    end
    return d;
  endfunction

  function automatic logic [127:0] rand_f();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand_w(input logic [127:0] f);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      case ($urandom % 4)
        0:       r[i*32 +: 32] = f[i*32 +: 32];
        1:       r[i*32 +: 32] = f[i*32 +: 32] + 32'd1;
        2:       r[i*32 +: 32] = f[i*32 +: 32] - 32'd1;
        default: r[i*32 +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  // One cycle of stimulus: inputs change on the falling edge, acceptance is
  // decided from the settled ready just after, and the rising edge commits it.
  task automatic drive(input bit v, input logic [127:0] f, input logic [127:0] w,
                       input logic [1:0] op, input logic [3:0] tag,
                       input bit rr, input bit clr, output bit acc);
    exp_t e;
    @(negedge clk);
    req_valid   = v;
    req_feature = f;
    req_weights = w;
    req_op      = op;
    req_tag     = tag;
    resp_ready  = rr;
    stat_clear  = clr;
    #1;
    acc = v && reset_n && u_req_ready;
    if (acc) begin
      e.dec_u = model(f, w, op, 1'b0);
      e.dec_s = model(f, w, op, 1'b1);
      e.tag   = tag;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit rr, input bit clr);
    bit acc;
    drive(1'b0, '0, '0, 2'd0, 4'd0, rr, clr, acc);
  endtask

  task automatic send(input logic [127:0] f, input logic [127:0] w, input logic [1:0] op,
                      input logic [3:0] tag, input bit rr);
    bit acc;
    for (int k = 0; k < 64; k++) begin
      drive(1'b1, f, w, op, tag, rr, 1'b0, acc);
      if (acc) return;
    end
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: pops on every response handshake; also checks outputs hold while stalled.
  logic [21:0] cur_out;
  logic [21:0] held_out;
  bit          stall_prev = 1'b0;
  exp_t        e_mon;

  assign cur_out = {u_resp_valid, u_dec, u_any, u_all, u_cnt, u_tag, s_dec, s_tag};

  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (stall_prev) chk("stall_hold", 64'(cur_out), 64'(held_out));
      if (u_resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e_mon = sb.pop_front();
          chk("resp_u", 64'({u_dec, u_any, u_all, u_cnt, u_tag}),
              64'({e_mon.dec_u, |e_mon.dec_u, &e_mon.dec_u, 3'($countones(e_mon.dec_u)), e_mon.tag}));
          chk("resp_s", 64'({s_resp_valid, s_dec, s_any, s_all, s_cnt, s_tag}),
              64'({1'b1, e_mon.dec_s, |e_mon.dec_s, &e_mon.dec_s, 3'($countones(e_mon.dec_s)), e_mon.tag}));
        end
        resp_seen++;
      end
      stall_prev = u_resp_valid && !resp_ready;
      held_out   = cur_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int nval, first_v, last_v, base;
    logic [127:0] f, w;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(u_resp_valid), 64'd0);
    chk("rst_req_ready",  64'(u_req_ready),  64'd1);
    chk("rst_bits", 64'({u_dec, u_any, u_all, u_cnt, u_tag}), 64'd0);
    chk("rst_stat", 64'(u_stat), 64'd0);
    #9 reset_n = 1'b1;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Directed compare and latency: lane0 first
    send({32'd9, 32'd7, 32'd5, 32'd3}, {32'd8, 32'd8, 32'd4, 32'd4}, 2'b00, 4'h7, 1'b1);
    idle(1'b1, 1'b0);
    chk("lat_n1_valid", 64'(u_resp_valid), 64'd0);
    idle(1'b1, 1'b0);
    chk("lat_n2_valid", 64'(u_resp_valid), 64'd1);
    chk("dir_decision", 64'(u_dec), 64'h5);
    chk("dir_any_all",  64'({u_any, u_all}), 64'b10);
    chk("dir_count",    64'(u_cnt), 64'd2);
    chk("dir_tag",      64'(u_tag), 64'h7);

    // Signed vs unsigned on 0xFFFFFFFF > 0
    send({96'd0, 32'hFFFF_FFFF}, 128'd0, 2'b10, 4'h3, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("gt_unsigned_lane0", 64'(u_dec[0]), 64'd1);
    chk("gt_signed_lane0",   64'(s_dec[0]), 64'd0);

    // 100 back-to-back requests
    idle(1'b1, 1'b1);
    nval = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 103; i++) begin
      f = rand_f();
      drive(i < 100, f, rand_w(f), 2'($urandom), 4'(i), 1'b1, 1'b0, acc);
      if (i < 100 && !acc) chk("stream_accept", 64'd0, 64'd1);
      if (u_resp_valid) begin
        nval++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    chk("stream_nresp", 64'(nval), 64'd100);
    chk("stream_first", 64'(first_v), 64'd2);
    chk("stream_last",  64'(last_v), 64'd101);
    chk("stream_stat_u", 64'(u_stat), 64'd100);
    chk("stream_stat_s", 64'(s_stat), 64'd100);

    // Backpressure: two accepted, third refused, then in-order release
    f = rand_f();
    drive(1'b1, f, rand_w(f), 2'd1, 4'h1, 1'b0, 1'b0, acc);
    chk("bp_acc1", 64'(acc), 64'd1);
    f = rand_f();
    drive(1'b1, f, rand_w(f), 2'd2, 4'h2, 1'b0, 1'b0, acc);
    chk("bp_acc2", 64'(acc), 64'd1);
    f = rand_f();
    w = rand_w(f);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, f, w, 2'd3, 4'h3, 1'b0, 1'b0, acc);
      chk("bp_acc3_refused", 64'(acc), 64'd0);
      chk("bp_req_ready", 64'({u_req_ready, s_req_ready}), 64'd0);
    end
    send(f, w, 2'd3, 4'h3, 1'b1);
    repeat (4) idle(1'b1, 1'b0);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 500; i++) begin
      f = rand_f();
      drive(($urandom % 3) != 0, f, rand_w(f), 2'($urandom), 4'($urandom),
            ($urandom % 4) != 0, 1'b0, acc);
    end
    repeat (4) idle(1'b1, 1'b0);
    chk("rand_drained", 64'(sb.size()), 64'd0);

    // Counter saturation and clear priority
    idle(1'b1, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      f = rand_f();
      drive(1'b1, f, rand_w(f), 2'($urandom), 4'(i), 1'b1, 1'b0, acc);
    end
    repeat (3) idle(1'b1, 1'b0);
    chk("stat_fffe", 64'(u_stat), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      f = rand_f();
      send(f, rand_w(f), 2'd0, 4'(i), 1'b1);
    end
    repeat (3) idle(1'b1, 1'b0);
    chk("stat_sat_u", 64'(u_stat), 64'hFFFF);
    chk("stat_sat_s", 64'(s_stat), 64'hFFFF);
    send(rand_f(), rand_f(), 2'd1, 4'h5, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    chk("clr_resp_pending", 64'(u_resp_valid), 64'd1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("clr_over_incr", 64'(u_stat), 64'd0);
    chk("clr_drained", 64'(sb.size()), 64'd0);

    // Reset with both stages full
    send(rand_f(), rand_f(), 2'd0, 4'hA, 1'b0);
    send(rand_f(), rand_f(), 2'd2, 4'hB, 1'b0);
    idle(1'b0, 1'b0);
    chk("full_resp_valid", 64'(u_resp_valid), 64'd1);
    chk("full_req_ready",  64'(u_req_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'({u_resp_valid, s_resp_valid}), 64'd0);
    chk("midrst_req_ready",  64'(u_req_ready), 64'd1);
    chk("midrst_bits", 64'({u_dec, u_any, u_all, u_cnt, u_tag}), 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #3 reset_n = 1'b1;
    base = resp_seen;
    repeat (10) idle(1'b1, 1'b0);
    chk("no_stale_resp", 64'(resp_seen), 64'(base));
    chk("midrst_stat", 64'(u_stat), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/comparator_array.md
COMPARATOR_ARRAY -- requirements
Module: comparator_array

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of each feature/weight lane.
REQ-002 SHALL have parameter LANES, default 4, meaning the number of parallel compare lanes (1..16).
REQ-003 SHALL have parameter SIGNED, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL have parameter TAG_W, default 4, meaning the width of the pass-through request tag.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  meaning the asynchronous, active-low reset.
REQ-007 SHALL have port io_req_valid  input  1  meaning the request is offered.
REQ-008 SHALL have port io_req_ready  output  1  meaning the block accepts the request this cycle.
REQ-009 SHALL have port io_req_bits_feature  input  LANES*WIDTH  meaning the features; lane i is bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port io_req_bits_weights  input  LANES*WIDTH  meaning the thresholds, packed like the features.
REQ-011 SHALL have port io_req_bits_op  input  2  meaning 00 f<w, 01 f<=w, 10 f>w, 11 f==w.
REQ-012 SHALL have port io_req_bits_tag  input  TAG_W  meaning the request identifier.
REQ-013 SHALL have port io_resp_valid  output  1  meaning the response is offered.
REQ-014 SHALL have port io_resp_ready  input  1  meaning the consumer accepts the response.
REQ-015 SHALL have port io_resp_bits_decision  output  LANES  meaning the per-lane compare result, with bit i for lane i.
REQ-016 SHALL have port io_resp_bits_any  output  1  meaning the OR of the decision bits.
REQ-017 SHALL have port io_resp_bits_all  output  1  meaning the AND of the decision bits.
REQ-018 SHALL have port io_resp_bits_count  output  $clog2(LANES+1)  meaning the popcount of the decision bits.
REQ-019 SHALL have port io_resp_bits_tag  output  TAG_W  meaning the tag of the request that produced the response.
REQ-020 SHALL have port io_stat_clear  input  1  meaning a synchronous clear of io_stat_count.
REQ-021 SHALL have port io_stat_count  output  16  meaning the saturating count of completed response handshakes.

Function
REQ-022 SHALL implement two register stages: A captures the request; B holds the decision, any/all/count and tag.
REQ-023 SHALL accept a request on a rising edge where io_req_valid && io_req_ready, loading stage A and setting a_valid.
REQ-024 SHALL drive io_req_ready = !a_valid || !b_valid || io_resp_ready; this combinational path from io_resp_ready is intended.
REQ-025 SHALL move A to B when a_valid && (!b_valid || io_resp_ready), computing the decision from the stage-A registers.
REQ-026 SHALL clear b_valid after a response handshake when no A-to-B transfer happens on the same edge.
REQ-027 SHALL assert io_resp_valid (= b_valid) two cycles after acceptance when there is no backpressure: accept in cycle N, respond in cycle N+2.
REQ-028 SHALL sustain one request per cycle while io_resp_ready is held high.
REQ-029 SHALL hold io_resp_bits_* stable while io_resp_valid && !io_resp_ready.
REQ-030 SHALL never drop, duplicate or reorder requests; with both stages full and io_resp_ready low, io_req_ready SHALL be 0.
REQ-031 SHALL compare unsigned when SIGNED=0 and as signed WIDTH-bit values when SIGNED=1; op applies to all lanes.
REQ-032 SHALL increment io_stat_count on each response handshake and saturate at 16'hFFFF.
REQ-033 SHALL give io_stat_clear priority over a simultaneous increment, so the count becomes 0.

Reset
REQ-034 SHALL, on reset_n low and independent of clk, clear a_valid, b_valid and io_stat_count.
REQ-035 SHALL hold io_resp_valid=0, io_req_ready=1, io_resp_bits_decision=0, any=0, all=0, count=0, tag=0 while reset_n is low.
REQ-036 SHALL discard any request in flight when reset asserts mid-operation; no response SHALL follow.

Verification (LANES=4, WIDTH=32)
REQ-037 Unsigned, op=00, f={3,5,7,9}, w={4,4,8,8} (lane0 first), resp_ready=1 -> cycle N+2: decision=4'b0101, any=1, all=0, count=2.
REQ-038 SIGNED=1, op=10, f lane0=32'hFFFFFFFF, w lane0=0 -> decision[0]=0; the same stimulus with SIGNED=0 -> decision[0]=1.
REQ-039 Hold resp_ready=0 and offer 3 requests -> 2 are accepted, req_ready=0 on the third; release -> tags return in order with no loss.
REQ-040 Stream 100 back-to-back requests with resp_ready=1 -> 100 responses in consecutive cycles; io_stat_count=100.
REQ-041 Preload io_stat_count to 16'hFFFE and complete 3 handshakes -> count=16'hFFFF; clear together with a handshake -> count=0.
REQ-042 Pull reset_n low while both stages are valid -> resp_valid=0 immediately; after release, no stale response appears.
